// File: rtl/oldland_arb_pkg.sv
// oldland_arb_pkg
// Shared definitions for the Oldland memory arbiter: the arbiter state
// encoding, the bus owner encoding and the default watchdog limit.
package oldland_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // The bus owner follows directly from the grant state.
    function automatic arb_owner_t state_owner(input arb_state_t s);
        return (s == GRANT_D) ? OWNER_D : OWNER_I;
    endfunction

endpackage

// File: rtl/oldland_arb_watchdog.sv
// oldland_arb_watchdog
// Busy-cycle counter that flags a transfer which has gone LIMIT cycles
// without completing. Only instantiated when OLDLAND_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold the counter at zero (arbiter idle)
//   expired    : high in the LIMIT-th busy cycle of a transfer
module oldland_arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else
            count <= count + 16'd1;
    end

    // The first busy cycle sees count 0, so count LIMIT-1 is busy cycle LIMIT.
    assign expired = !clear && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/oldland_mem_arbiter.sv
// oldland_mem_arbiter
// Shares the Oldland memory bus between instruction fetch (I) and the
// load/store unit (D). D has fixed priority over I. Acks and read data are
// returned combinationally in the bus_ack cycle to the owning requester.
// Optional feature: define OLDLAND_ARB_TIMEOUT_EN to add a watchdog that
// aborts transfers not acknowledged within TIMEOUT_CYCLES busy cycles; the
// aborted requester sees its ack with its error flag high and data 0.
//
// States:
//   IDLE    | no transfer; arbitrate (D before I)
//   GRANT_I | bus owned by the fetch unit, waiting for bus_ack
//   GRANT_D | bus owned by the LSU, waiting for bus_ack
//
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   i_access/i_addr -> i_ack/i_data/i_error         : fetch port
//   d_access/d_addr/d_wr_en/d_bytesel/d_wr_val
//                   -> d_ack/d_data/d_error         : load/store port
//   bus_access/bus_addr/bus_wr_en/bus_bytesel/bus_wr_val,
//   bus_ack/bus_data                                : external bus
module oldland_mem_arbiter
    import oldland_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_access,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_data,
    input  logic        d_access,
    input  logic [31:0] d_addr,
    input  logic        d_wr_en,
    input  logic [3:0]  d_bytesel,
    input  logic [31:0] d_wr_val,
    output logic        d_ack,
    output logic [31:0] d_data,
    output logic        d_error,
    output logic        i_error,
    output logic        bus_access,
    output logic [31:0] bus_addr,
    output logic        bus_wr_en,
    output logic [3:0]  bus_bytesel,
    output logic [31:0] bus_wr_val,
    input  logic        bus_ack,
    input  logic [31:0] bus_data
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("oldland_mem_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    arb_state_t state, state_next;
    arb_owner_t owner;
    logic       busy;
    logic       timeout;
    logic       done;
    logic       grant_entry;

    assign busy  = (state != IDLE);
    assign owner = state_owner(state);

`ifdef OLDLAND_ARB_TIMEOUT_EN
    oldland_arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!busy),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // bus_ack takes precedence over a coincident timeout.
    assign done = busy && (bus_ack || timeout);

    always_comb begin
        state_next  = state;
        grant_entry = 1'b0;
        case (state)
            IDLE: begin
                if (d_access) begin
                    state_next  = GRANT_D;
                    grant_entry = 1'b1;
                end else if (i_access) begin
                    state_next  = GRANT_I;
                    grant_entry = 1'b1;
                end
            end
            GRANT_I, GRANT_D: begin
                if (done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus_access  <= 1'b0;
            bus_addr    <= '0;
            bus_wr_en   <= 1'b0;
            bus_bytesel <= '0;
            bus_wr_val  <= '0;
        end else begin
            state      <= state_next;
            bus_access <= (state_next != IDLE);
            if (grant_entry) begin
                if (state_next == GRANT_D) begin
                    bus_addr    <= d_addr;
                    bus_wr_en   <= d_wr_en;
                    bus_bytesel <= d_bytesel;
                    bus_wr_val  <= d_wr_val;
                end else begin
                    bus_addr    <= i_addr;
                    bus_wr_en   <= 1'b0;
                    bus_bytesel <= 4'hf;
                    bus_wr_val  <= '0;
                end
            end
        end
    end

    // Zero-latency return path; data is only passed through on a real bus_ack.
    assign i_ack   = done && (owner == OWNER_I);
    assign d_ack   = done && (owner == OWNER_D);
    assign i_data  = (i_ack && bus_ack) ? bus_data : '0;
    assign d_data  = (d_ack && bus_ack) ? bus_data : '0;
`ifdef OLDLAND_ARB_TIMEOUT_EN
    assign i_error = i_ack && !bus_ack;
    assign d_error = d_ack && !bus_ack;
`else
    assign i_error = 1'b0;
    assign d_error = 1'b0;
`endif

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
// tb_oldland_mem_arbiter
// Directed bench for oldland_mem_arbiter. Inputs are driven on the falling
// edge; outputs are sampled on the falling edge or 1ns after an input change
// for the combinational return path.
`timescale 1ns/1ps
module tb_oldland_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_access, d_access, d_wr_en, bus_ack;
    logic [31:0] i_addr, d_addr, d_wr_val, bus_data;
    logic [3:0]  d_bytesel;
    logic        i_ack, d_ack, i_error, d_error, bus_access, bus_wr_en;
    logic [31:0] i_data, d_data, bus_addr, bus_wr_val;
    logic [3:0]  bus_bytesel;

    int n_compared = 0;
    int n_mismatched = 0;

    oldland_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_access(i_access), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
        .d_access(d_access), .d_addr(d_addr), .d_wr_en(d_wr_en),
        .d_bytesel(d_bytesel), .d_wr_val(d_wr_val), .d_ack(d_ack),
        .d_data(d_data), .d_error(d_error), .i_error(i_error),
        .bus_access(bus_access), .bus_addr(bus_addr), .bus_wr_en(bus_wr_en),
        .bus_bytesel(bus_bytesel), .bus_wr_val(bus_wr_val),
        .bus_ack(bus_ack), .bus_data(bus_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_access = 1'b0; i_addr = '0; d_access = 1'b0; d_addr = '0;
        d_wr_en = 1'b0; d_bytesel = '0; d_wr_val = '0;
        bus_ack = 1'b0; bus_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_bus_access", 32'(bus_access), 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_i_ack", 32'(i_ack), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        check("rst_bus_bytesel", 32'(bus_bytesel), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1. Fetch only, ack in 3rd busy cycle
        @(negedge clk);
        i_access = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        check("t1_bus_access", 32'(bus_access), 1);
        check("t1_bus_addr", bus_addr, 32'h100);
        check("t1_bytesel", 32'(bus_bytesel), 32'hf);
        check("t1_wr_en", 32'(bus_wr_en), 0);
        bus_data = 32'h5555_aaaa;
        check("t1_i_data_zero_no_ack", i_data, 0);
        @(negedge clk);
        check("t1_i_ack_early", 32'(i_ack), 0);
        @(negedge clk);
        bus_ack = 1'b1; bus_data = 32'hdeadbeef;
        #1;
        check("t1_i_ack", 32'(i_ack), 1);
        check("t1_i_data", i_data, 32'hdeadbeef);
        check("t1_d_ack", 32'(d_ack), 0);
        check("t1_i_error", 32'(i_error), 0);
        @(negedge clk);
        i_access = 1'b0; bus_ack = 1'b0;
        check("t1_bus_access_after", 32'(bus_access), 0);
        check("t1_i_ack_once", 32'(i_ack), 0);

        // 2. Simultaneous requests, D first
        @(negedge clk);
        i_access = 1'b1; i_addr = 32'h100;
        d_access = 1'b1; d_addr = 32'h2000; d_wr_en = 1'b0; d_bytesel = 4'hf;
        @(negedge clk);
        check("t2_first_addr", bus_addr, 32'h2000);
        check("t2_first_wr_en", 32'(bus_wr_en), 0);
        bus_ack = 1'b1; bus_data = 32'hcafe_0001;
        #1;
        check("t2_d_ack", 32'(d_ack), 1);
        check("t2_d_data", d_data, 32'hcafe_0001);
        check("t2_i_ack_blocked", 32'(i_ack), 0);
        check("t2_i_data_zero", i_data, 0);
        @(negedge clk);
        d_access = 1'b0; bus_ack = 1'b0;
        check("t2_idle_gap", 32'(bus_access), 0);
        @(negedge clk);
        check("t2_second_access", 32'(bus_access), 1);
        check("t2_second_addr", bus_addr, 32'h100);
        check("t2_second_bytesel", 32'(bus_bytesel), 32'hf);
        bus_ack = 1'b1; bus_data = 32'h0000_0bad;
        #1;
        check("t2_i_ack", 32'(i_ack), 1);
        check("t2_i_data", i_data, 32'h0000_0bad);
        @(negedge clk);
        i_access = 1'b0; bus_ack = 1'b0;

        // 3. Store
        @(negedge clk);
        d_access = 1'b1; d_addr = 32'h3000; d_wr_en = 1'b1;
        d_bytesel = 4'b0011; d_wr_val = 32'h0000_1234;
        @(negedge clk);
        check("t3_addr", bus_addr, 32'h3000);
        check("t3_wr_en", 32'(bus_wr_en), 1);
        check("t3_bytesel", 32'(bus_bytesel), 32'h3);
        check("t3_wr_val", bus_wr_val, 32'h0000_1234);
        bus_ack = 1'b1; bus_data = 32'h0;
        #1;
        check("t3_d_ack", 32'(d_ack), 1);
        @(negedge clk);
        d_access = 1'b0; bus_ack = 1'b0; d_wr_en = 1'b0;
        check("t3_d_ack_once", 32'(d_ack), 0);

        // 4. Unacknowledged transfer
`ifdef OLDLAND_ARB_TIMEOUT_EN
        @(negedge clk);
        d_access = 1'b1; d_addr = 32'h4000; bus_data = 32'h1357_9bdf;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8)
                check($sformatf("t4_no_ack_c%0d", k), 32'(d_ack), 0);
        end
        check("t4_to_d_ack", 32'(d_ack), 1);
        check("t4_to_d_error", 32'(d_error), 1);
        check("t4_to_d_data", d_data, 0);
        @(negedge clk);
        d_access = 1'b0;
        check("t4_to_bus_access", 32'(bus_access), 0);
        @(negedge clk);
        d_access = 1'b1;
        for (int k = 1; k <= 8; k++) @(negedge clk);
        bus_ack = 1'b1; bus_data = 32'h2468_ace0;
        #1;
        check("t4_tie_d_ack", 32'(d_ack), 1);
        check("t4_tie_d_error", 32'(d_error), 0);
        check("t4_tie_d_data", d_data, 32'h2468_ace0);
        @(negedge clk);
        d_access = 1'b0; bus_ack = 1'b0;
`else
        @(negedge clk);
        d_access = 1'b1; d_addr = 32'h4000;
        repeat (20) @(negedge clk);
        check("t4_still_granted", 32'(bus_access), 1);
        check("t4_no_d_ack", 32'(d_ack), 0);
        bus_ack = 1'b1; bus_data = 32'h2468_ace0;
        #1;
        check("t4_late_d_ack", 32'(d_ack), 1);
        check("t4_d_error_tied", 32'(d_error), 0);
        check("t4_late_d_data", d_data, 32'h2468_ace0);
        @(negedge clk);
        d_access = 1'b0; bus_ack = 1'b0;
`endif

        // 6. Spurious ack in IDLE
        @(negedge clk);
        bus_ack = 1'b1; bus_data = 32'hffff_ffff;
        #1;
        check("t6_i_ack", 32'(i_ack), 0);
        check("t6_d_ack", 32'(d_ack), 0);
        check("t6_i_data", i_data, 0);
        @(negedge clk);
        bus_ack = 1'b0;
        check("t6_stay_idle", 32'(bus_access), 0);

        // 5. Reset mid-transfer
        @(negedge clk);
        i_access = 1'b1; i_addr = 32'h500;
        repeat (2) @(negedge clk);
        check("t5_busy", 32'(bus_access), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_drop", 32'(bus_access), 0);
        check("t5_no_i_ack", 32'(i_ack), 0);
        @(negedge clk);
        i_access = 1'b0;
        bus_ack = 1'b1; bus_data = 32'h1111_1111;
        #1;
        check("t5_no_ack_in_reset", 32'(i_ack), 0);
        @(negedge clk);
        bus_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_idle_after", 32'(bus_access), 0);
        i_access = 1'b1; i_addr = 32'h600;
        @(negedge clk);
        check("t5_regrant", 32'(bus_access), 1);
        check("t5_regrant_addr", bus_addr, 32'h600);
        bus_ack = 1'b1; bus_data = 32'h7777_0000;
        #1;
        check("t5_i_ack", 32'(i_ack), 1);
        check("t5_i_data", i_data, 32'h7777_0000);
        @(negedge clk);
        i_access = 1'b0; bus_ack = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
